// File: rtl/mem_pkg.sv
// Shared types and constants for the Mini SRC memory responder.
package mem_pkg;

  // Responder sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DATA_W     = 32;
  localparam int BUS_ADDR_W = 32;
  localparam int DEF_ADDR_W = 9;
  // Wait counter width; supports 0..15 wait states.
  localparam int CNT_W      = 4;

  // Mask selecting the MAR bits that lie above the implemented word address.
  // Any set bit under this mask marks the request as out of range.
  function automatic logic [BUS_ADDR_W-1:0] upper_addr_mask(input int addr_w);
    logic [BUS_ADDR_W-1:0] low_ones;
    low_ones = (BUS_ADDR_W'(1) << addr_w) - BUS_ADDR_W'(1);
    return ~low_ones;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the Mini SRC control path (MAR/MDR side)
// and the memory responder.
interface mem_responder_if;
  import mem_pkg::*;

  logic                  Read;
  logic                  Write;
  logic [BUS_ADDR_W-1:0] Address;
  logic [DATA_W-1:0]     Data_In;
  logic [DATA_W-1:0]     MData_Out;
  logic                  Done;
  logic                  Busy;
  logic                  Addr_Err;

  // Control path side: issues requests, consumes completion.
  modport master (
    output Read, Write, Address, Data_In,
    input  MData_Out, Done, Busy, Addr_Err
  );

  // Memory side: services requests.
  modport slave (
    input  Read, Write, Address, Data_In,
    output MData_Out, Done, Busy, Addr_Err
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with registered read.
// The array itself has no reset; only the read-data register is cleared so
// the data lines present zero after reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_reg;

  // Write port: contents only change on an enabled write.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read: holds its value until the next enabled read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (en && !we) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a read or write from the control path,
// waits WAIT_CYCLES, performs one access on the internal RAM and signals
// completion with a one-cycle Done pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            Clock,
  input  logic            Clear,
  mem_responder_if.slave  bus
);

  localparam logic [BUS_ADDR_W-1:0] UPPER_MASK = upper_addr_mask(ADDR_W);
  localparam logic [CNT_W-1:0]      WAIT_LOAD  = CNT_W'(WAIT_CYCLES);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic                accept;

  // Request fields captured at acceptance and used for the whole operation.
  logic [ADDR_W-1:0]   addr_lat;
  logic [DATA_W-1:0]   data_lat;
  logic                write_lat;
  logic                err_lat;

  logic                done_reg;
  logic                busy_reg;
  logic                addr_err_reg;

  logic                mem_en;
  logic [DATA_W-1:0]   mem_rdata;
  logic                req_err;

  // Both request lines high, or any address bit beyond the RAM, is an error.
  assign req_err = (bus.Read & bus.Write) | (|(bus.Address & UPPER_MASK));

  // State and wait-counter registers.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; request lines are only looked at in IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.Read || bus.Write) begin
          accept   = 1'b1;
          cnt_next = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_next = ST_ACCESS;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Capture the request on acceptance.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      addr_lat  <= '0;
      data_lat  <= '0;
      write_lat <= 1'b0;
      err_lat   <= 1'b0;
    end else if (accept) begin
      addr_lat  <= bus.Address[ADDR_W-1:0];
      data_lat  <= bus.Data_In;
      write_lat <= bus.Write;
      err_lat   <= req_err;
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      addr_err_reg <= 1'b0;
    end else begin
      done_reg     <= (state_next == ST_DONE);
      busy_reg     <= (state_next != ST_IDLE);
      addr_err_reg <= (state_next == ST_DONE) && err_lat;
    end
  end

  // The single RAM access happens on the edge that leaves ACCESS; erroneous
  // requests never touch the RAM, so MData_Out keeps its previous value.
  assign mem_en = (state == ST_ACCESS) && !err_lat;

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk   (Clock),
    .rst_n (Clear),
    .en    (mem_en),
    .we    (write_lat),
    .addr  (addr_lat),
    .wdata (data_lat),
    .rdata (mem_rdata)
  );

  assign bus.MData_Out = mem_rdata;
  assign bus.Done      = done_reg;
  assign bus.Busy      = busy_reg;
  assign bus.Addr_Err  = addr_err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: two instances (2 and 0 wait states)
// driven by directed steps plus random traffic, checked against a word-array
// reference model.
module tb_mem_responder;

  logic clk;
  logic clear;

  logic        rd_v [0:1];
  logic        wr_v [0:1];
  logic [31:0] ad_v [0:1];
  logic [31:0] di_v [0:1];

  logic [31:0] mdata_o [0:1];
  logic        done_o  [0:1];
  logic        busy_o  [0:1];
  logic        err_o   [0:1];

  int checks = 0;
  int errors = 0;

  // Reference model: memory image and last read value per instance.
  logic [31:0] model_mem [0:1][0:511];
  logic [31:0] model_mdata [0:1];

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  assign bus0.Read    = rd_v[0];
  assign bus0.Write   = wr_v[0];
  assign bus0.Address = ad_v[0];
  assign bus0.Data_In = di_v[0];
  assign bus1.Read    = rd_v[1];
  assign bus1.Write   = wr_v[1];
  assign bus1.Address = ad_v[1];
  assign bus1.Data_In = di_v[1];

  assign mdata_o[0] = bus0.MData_Out;
  assign done_o[0]  = bus0.Done;
  assign busy_o[0]  = bus0.Busy;
  assign err_o[0]   = bus0.Addr_Err;
  assign mdata_o[1] = bus1.MData_Out;
  assign done_o[1]  = bus1.Done;
  assign busy_o[1]  = bus1.Busy;
  assign err_o[1]   = bus1.Addr_Err;

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut_w2 (
    .Clock (clk),
    .Clear (clear),
    .bus   (bus0)
  );

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut_w0 (
    .Clock (clk),
    .Clear (clear),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input int d, input string tag);
    check($sformatf("%s_mdata_d%0d", tag, d), mdata_o[d], 32'h0);
    check($sformatf("%s_done_d%0d", tag, d), {31'b0, done_o[d]}, 32'h0);
    check($sformatf("%s_busy_d%0d", tag, d), {31'b0, busy_o[d]}, 32'h0);
    check($sformatf("%s_err_d%0d", tag, d), {31'b0, err_o[d]}, 32'h0);
  endtask

  // One complete transaction on instance d, starting at a negedge with the
  // instance idle. With junk set, random request activity is applied while
  // the instance is busy (before the Done cycle) and must be ignored.
  task automatic run_req(input int d, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] data,
                         input bit junk, input bit verbose);
    int   wc;
    bit   exp_err;
    logic [8:0] idx;
    wc      = wait_of(d);
    idx     = a[8:0];
    exp_err = (r && w) || (a[31:9] != 23'd0);
    if (!exp_err && w) model_mem[d][idx] = data;
    if (!exp_err && r && !w) model_mdata[d] = model_mem[d][idx];

    rd_v[d] = r; wr_v[d] = w; ad_v[d] = a; di_v[d] = data;
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n <= wc + 2; n++) begin
      check($sformatf("busy_d%0d_n%0d", d, n), {31'b0, busy_o[d]}, {31'b0, (n <= wc + 1)});
      check($sformatf("done_d%0d_n%0d", d, n), {31'b0, done_o[d]}, {31'b0, (n == wc + 1)});
      if (n == wc + 1) begin
        check($sformatf("addr_err_d%0d", d), {31'b0, err_o[d]}, {31'b0, exp_err});
        check($sformatf("mdata_d%0d", d), mdata_o[d], model_mdata[d]);
      end
      if (n <= wc && junk) begin
        rd_v[d] = 1'($urandom); wr_v[d] = 1'($urandom);
        ad_v[d] = $urandom;     di_v[d] = $urandom;
      end else begin
        rd_v[d] = 1'b0; wr_v[d] = 1'b0; ad_v[d] = '0; di_v[d] = '0;
      end
      if (n < wc + 2) @(negedge clk);
    end
    if (verbose)
      $display("txn d%0d rd=%0b wr=%0b addr=%h data=%h err=%0b mdata=%h",
               d, r, w, a, data, exp_err, mdata_o[d]);
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    int          kind;
    bit          r;
    bit          w;

    for (int i = 0; i < 2; i++) begin
      rd_v[i] = 1'b0; wr_v[i] = 1'b0; ad_v[i] = '0; di_v[i] = '0;
      model_mdata[i] = '0;
    end

    // Power-on reset state.
    clear = 1'b0;
    #1;
    check_cleared(0, "por");
    check_cleared(1, "por");
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;

    // Give every word a known value so the model covers all addresses.
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 512; k++)
        run_req(i, 1'b0, 1'b1, 32'(k), $urandom, 1'b1, 1'b0);

    // Write then read with two wait states.
    run_req(0, 1'b0, 1'b1, 32'h0000001F, 32'hDEADBEEF, 1'b0, 1'b1);
    run_req(0, 1'b1, 1'b0, 32'h0000001F, 32'h0, 1'b0, 1'b1);
    check("w2_read_value", mdata_o[0], 32'hDEADBEEF);

    // Zero wait states.
    run_req(1, 1'b0, 1'b1, 32'h00000005, 32'h12345678, 1'b0, 1'b1);
    run_req(1, 1'b1, 1'b0, 32'h00000005, 32'h0, 1'b0, 1'b1);
    check("w0_read_value", mdata_o[1], 32'h12345678);

    // Out-of-range write, then confirm word 0 untouched.
    run_req(0, 1'b0, 1'b1, 32'h00000200, 32'hFFFFFFFF, 1'b0, 1'b1);
    run_req(0, 1'b1, 1'b0, 32'h00000000, 32'h0, 1'b0, 1'b1);

    // Read and Write together: error, no memory change, data unchanged.
    run_req(0, 1'b1, 1'b1, 32'h00000003, 32'h55AA55AA, 1'b0, 1'b1);
    run_req(0, 1'b1, 1'b0, 32'h00000003, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset while idle, with non-zero read data present.
    run_req(0, 1'b1, 1'b0, 32'h0000001F, 32'h0, 1'b0, 1'b1);
    #2;
    clear = 1'b0;
    #1;
    check_cleared(0, "idle_rst");
    check_cleared(1, "idle_rst");
    model_mdata[0] = '0;
    model_mdata[1] = '0;
    @(negedge clk);
    clear = 1'b1;

    // Reset during WAIT of a write: aborted, no Done, old data kept.
    rd_v[0] = 1'b0; wr_v[0] = 1'b1; ad_v[0] = 32'h10; di_v[0] = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    rd_v[0] = 1'b0; wr_v[0] = 1'b0; ad_v[0] = '0; di_v[0] = '0;
    check("wait_busy_before_rst", {31'b0, busy_o[0]}, 32'h1);
    #2;
    clear = 1'b0;
    #1;
    check_cleared(0, "wait_rst");
    @(negedge clk);
    clear = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check($sformatf("no_done_after_abort_%0d", n), {31'b0, done_o[0]}, 32'h0);
    end
    run_req(0, 1'b1, 1'b0, 32'h00000010, 32'h0, 1'b0, 1'b1);

    // Random traffic with activity while busy.
    for (int t = 0; t < 200; t++) begin
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 19));
      a    = 32'($urandom_range(0, 511));
      if (kind == 0) begin
        r = 1'b1; w = 1'b1;
      end else begin
        r = 1'($urandom); w = ~r;
        if (kind == 1) a = a | (32'($urandom_range(1, 8388607)) << 9);
      end
      run_req(d, r, w, a, $urandom, 1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
